// File: rtl/mdio_frame.sv
// Clause 22 MDIO management-frame engine. Consumes the per-bit strobe and
// sampled bit from the pin stage. It decodes the frame fields and turns each
// frame into a request on a simple register bus. Read data is serialised back
// through mdo/mdo_valid.
module mdio_frame #(
    parameter logic [4:0] PHYAD    = 5'd0,
    parameter int         PREAMBLE = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        mdi,
    output logic        mdo,
    output logic        mdo_valid,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_data_write,
    output logic        reg_read,
    output logic        reg_write,
    input  logic        reg_ack,
    input  logic [15:0] reg_data_read
);

    localparam logic [5:0] PRE_MAX = 6'(PREAMBLE);

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;      // OP/PHYAD/REGAD/DATA bits, MSB first
    logic [4:0]  regad_q, regad_d;      // REGAD of the frame being decoded
    logic        is_read_q, is_read_d;
    logic        acked_q, acked_d;      // read data arrived in time to drive
    logic [15:0] rd_data_q, rd_data_d;  // read data, shifted out MSB first
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [15:0] reg_data_write_q, reg_data_write_d;
    logic        reg_read_q, reg_read_d;
    logic        reg_write_q, reg_write_d;
    logic        mdo_q, mdo_d;
    logic        mdo_valid_q, mdo_valid_d;
    logic [15:0] shifted;
    logic        ack_in_time;

    assign shifted = {shift_q[14:0], mdi};
    // An ack counts for driving only if it lands before the data phase.
    assign ack_in_time = reg_ack && reg_read_q && (state_q != S_DATA);

    // State and output registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            pre_cnt_q        <= '0;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            regad_q          <= '0;
            is_read_q        <= 1'b0;
            acked_q          <= 1'b0;
            rd_data_q        <= '0;
            reg_addr_q       <= '0;
            reg_data_write_q <= '0;
            reg_read_q       <= 1'b0;
            reg_write_q      <= 1'b0;
            mdo_q            <= 1'b0;
            mdo_valid_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            pre_cnt_q        <= pre_cnt_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            regad_q          <= regad_d;
            is_read_q        <= is_read_d;
            acked_q          <= acked_d;
            rd_data_q        <= rd_data_d;
            reg_addr_q       <= reg_addr_d;
            reg_data_write_q <= reg_data_write_d;
            reg_read_q       <= reg_read_d;
            reg_write_q      <= reg_write_d;
            mdo_q            <= mdo_d;
            mdo_valid_q      <= mdo_valid_d;
        end
    end

    // Bus handshake every cycle, frame decoding on ce cycles only.
    always_comb begin
        state_d          = state_q;
        pre_cnt_d        = pre_cnt_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        regad_d          = regad_q;
        is_read_d        = is_read_q;
        acked_d          = acked_q;
        rd_data_d        = rd_data_q;
        reg_addr_d       = reg_addr_q;
        reg_data_write_d = reg_data_write_q;
        reg_read_d       = reg_read_q;
        reg_write_d      = reg_write_q;
        mdo_d            = mdo_q;
        mdo_valid_d      = mdo_valid_q;

        if (reg_ack && reg_write_q) begin
            reg_write_d = 1'b0;
        end
        if (reg_ack && reg_read_q) begin
            reg_read_d = 1'b0;
            if (ack_in_time) begin
                rd_data_d = reg_data_read;
                acked_d   = 1'b1;
            end
        end

        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (mdi) begin
                        if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q == PRE_MAX) begin
                        state_d   = S_ST;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                S_ST: begin
                    bit_cnt_d = '0;
                    state_d   = mdi ? S_OP : S_IDLE;
                end
                S_OP: begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd1) begin
                        bit_cnt_d = '0;
                        state_d   = S_PHY;
                        if (shifted[1:0] == 2'b10)      is_read_d = 1'b1;
                        else if (shifted[1:0] == 2'b01) is_read_d = 1'b0;
                        else                            state_d   = S_IDLE;
                    end
                end
                S_PHY: begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        state_d   = (shifted[4:0] == PHYAD) ? S_REG : S_IDLE;
                    end
                end
                S_REG: begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        regad_d   = shifted[4:0];
                        state_d   = S_TA;
                        acked_d   = 1'b0;
                        // A write still waiting for its ack keeps the bus.
                        if (is_read_q && !reg_write_q) begin
                            reg_read_d = 1'b1;
                            reg_addr_d = shifted[4:0];
                        end
                    end
                end
                S_TA: begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd1) begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                        if (is_read_q && (acked_q || ack_in_time)) begin
                            mdo_valid_d = 1'b1;
                            mdo_d       = 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (is_read_q) begin
                        if (bit_cnt_q != 5'd16) begin
                            mdo_d     = mdo_valid_q & rd_data_q[15];
                            rd_data_d = {rd_data_q[14:0], 1'b0};
                        end else begin
                            // One extra ce releases the line and ends the frame.
                            mdo_valid_d = 1'b0;
                            mdo_d       = 1'b0;
                            reg_read_d  = 1'b0;
                            bit_cnt_d   = '0;
                            state_d     = S_IDLE;
                        end
                    end else if (bit_cnt_q == 5'd15) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        if (!reg_write_q && !reg_read_q) begin
                            reg_write_d      = 1'b1;
                            reg_addr_d       = regad_q;
                            reg_data_write_d = shifted;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign mdo            = mdo_q;
    assign mdo_valid      = mdo_valid_q;
    assign reg_addr       = reg_addr_q;
    assign reg_data_write = reg_data_write_q;
    assign reg_read       = reg_read_q;
    assign reg_write      = reg_write_q;

endmodule

// File: tb/tb_mdio_frame.sv
// Scoreboard bench for mdio_frame: frames are driven bit by bit, expected
// bus requests and MDIO output bits are queued, and a monitor compares them.
module tb_mdio_frame;

    localparam logic [4:0] MY_PHY = 5'd1;
    localparam int K_RD = 0, K_WR = 1, K_BIT = 2, K_REL = 3;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n, ce, mdi, mdo, mdo_valid, reg_read, reg_write, reg_ack;
    logic [4:0]  reg_addr;
    logic [15:0] reg_data_write, reg_data_read;

    ev_t         sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        rd_ack_en = 1'b1;
    logic [15:0] rd_val = 16'h0000;

    mdio_frame #(.PHYAD(MY_PHY), .PREAMBLE(32)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .mdi(mdi),
        .mdo(mdo), .mdo_valid(mdo_valid),
        .reg_addr(reg_addr), .reg_data_write(reg_data_write),
        .reg_read(reg_read), .reg_write(reg_write),
        .reg_ack(reg_ack), .reg_data_read(reg_data_read)
    );

    always #5 clk = ~clk;

    task automatic pop_check(input int kind, input logic [4:0] a, input logic [15:0] d);
        ev_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%h, required no event", kind, a, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.addr != a || e.data != d) begin
                n_bad++;
                $display("FAIL event: got kind=%0d addr=%0d data=%h, required kind=%0d addr=%0d data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end else begin
                $display("ok   event kind=%0d addr=%0d data=%h", kind, a, d);
            end
        end
    endtask

    task automatic push_ev(input int kind, input logic [4:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    // Expected response to one read frame: request, then optionally the driven bits.
    task automatic expect_read(input logic [4:0] a, input logic [15:0] d, input bit driven);
        push_ev(K_RD, a, 16'h0);
        if (driven) begin
            push_ev(K_BIT, 5'd0, 16'h0);
            for (int i = 15; i >= 0; i--) push_ev(K_BIT, 5'd0, {15'h0, d[i]});
            push_ev(K_REL, 5'd0, 16'h0);
        end
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        mdi = b; ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Read frame; the master releases the line in TA/DATA so mdi reads 1.
    // ndata = 17 covers the 16 data bits plus the release ce.
    task automatic rd_frame(input int pre, input logic [4:0] phy, input logic [4:0] ra, input int ndata);
        for (int i = 0; i < pre; i++) send_bit(1'b1);
        send_bits({18'h0, 2'b01, 2'b10, phy, ra}, 14);
        send_bits(32'h3, 2);
        send_bits(32'hFFFF_FFFF, ndata);
    endtask

    task automatic wr_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
        for (int i = 0; i < 32; i++) send_bit(1'b1);
        send_bits({18'h0, 2'b01, 2'b01, phy, ra}, 14);
        send_bits(32'h2, 2);
        send_bits({16'h0, d}, 16);
    endtask

    task automatic check_drained(input string nm);
        repeat (10) @(posedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d events still expected, required 0", nm, sb.size());
            sb.delete();
        end else begin
            $display("ok   %s all expected events seen", nm);
        end
    endtask

    // Monitor: request rising edges, and mdo/mdo_valid after each consumed ce.
    initial begin
        logic prev_v, prev_rd, prev_wr, ce_d;
        prev_v = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; ce_d = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; ce_d = 1'b0;
            end else begin
                if (reg_read && !prev_rd)  pop_check(K_RD, reg_addr, 16'h0);
                if (reg_write && !prev_wr) pop_check(K_WR, reg_addr, reg_data_write);
                if (ce_d) begin
                    if (mdo_valid)   pop_check(K_BIT, 5'd0, {15'h0, mdo});
                    else if (prev_v) pop_check(K_REL, 5'd0, 16'h0);
                end
                prev_v = mdo_valid; prev_rd = reg_read; prev_wr = reg_write; ce_d = ce;
            end
        end
    end

    // Register-bus responder: writes acked next cycle, reads after 2 clocks.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && reg_write) begin
                reg_ack = 1'b1;
                @(negedge clk);
                reg_ack = 1'b0;
                n_vec++;
                if (reg_write !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wr_drop: got reg_write=%b, required 0 after ack", reg_write);
                end
            end else if (rst_n && reg_read && rd_ack_en) begin
                repeat (2) @(negedge clk);
                reg_ack = 1'b1;
                reg_data_read = rd_val;
                @(negedge clk);
                reg_ack = 1'b0;
                reg_data_read = 16'h0;
                n_vec++;
                if (reg_read !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rd_drop: got reg_read=%b, required 0 after ack", reg_read);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ce = 1'b0; mdi = 1'b1;
        reg_ack = 1'b0; reg_data_read = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({mdo, mdo_valid, reg_read, reg_write, reg_addr, reg_data_write} !== 25'h0) begin
            n_bad++;
            $display("FAIL reset_state: got mdo=%b v=%b rd=%b wr=%b addr=%h wd=%h, required all 0",
                     mdo, mdo_valid, reg_read, reg_write, reg_addr, reg_data_write);
        end
        #2 rst_n = 1'b1;

        // T1: read reg 3, acked with 0xA55A
        rd_val = 16'hA55A;
        expect_read(5'd3, 16'hA55A, 1'b1);
        rd_frame(32, MY_PHY, 5'd3, 17);
        check_drained("T1_read");

        // T2: write 0x1234 to reg 4
        push_ev(K_WR, 5'd4, 16'h1234);
        wr_frame(MY_PHY, 5'd4, 16'h1234);
        check_drained("T2_write");

        // T3: 31-bit preamble, nothing happens
        rd_frame(31, MY_PHY, 5'd5, 17);
        check_drained("T3_short_pre");

        // T4: frame for PHY 2 ignored, then PHY 1 served
        rd_frame(32, 5'd2, 5'd6, 17);
        check_drained("T4_mismatch");
        rd_val = 16'h0F0F;
        expect_read(5'd7, 16'h0F0F, 1'b1);
        rd_frame(32, MY_PHY, 5'd7, 17);
        check_drained("T4_served");

        // T5: read never acked, then a normal read
        rd_ack_en = 1'b0;
        expect_read(5'd9, 16'h0, 1'b0);
        rd_frame(32, MY_PHY, 5'd9, 17);
        #1;
        n_vec++;
        if (reg_read !== 1'b0) begin
            n_bad++;
            $display("FAIL T5_rd_clear: got reg_read=%b, required 0 at frame end", reg_read);
        end
        check_drained("T5_noack");
        rd_ack_en = 1'b1;
        rd_val = 16'h8001;
        expect_read(5'd10, 16'h8001, 1'b1);
        rd_frame(32, MY_PHY, 5'd10, 17);
        check_drained("T5_next");

        // T6: reset in the middle of driven read data (0xC3C3, first 5 bits 11000)
        rd_val = 16'hC3C3;
        push_ev(K_RD, 5'd12, 16'h0);
        push_ev(K_BIT, 5'd0, 16'h0);
        push_ev(K_BIT, 5'd0, 16'h1);
        push_ev(K_BIT, 5'd0, 16'h1);
        push_ev(K_BIT, 5'd0, 16'h0);
        push_ev(K_BIT, 5'd0, 16'h0);
        push_ev(K_BIT, 5'd0, 16'h0);
        rd_frame(32, MY_PHY, 5'd12, 5);
        n_vec++;
        if (mdo_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL T6_driving: got mdo_valid=%b, required 1 before reset", mdo_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({mdo, mdo_valid, reg_read, reg_write, reg_addr, reg_data_write} !== 25'h0) begin
            n_bad++;
            $display("FAIL T6_reset: got mdo=%b v=%b rd=%b wr=%b addr=%h wd=%h, required all 0",
                     mdo, mdo_valid, reg_read, reg_write, reg_addr, reg_data_write);
        end
        check_drained("T6_abort");
        #3 rst_n = 1'b1;
        push_ev(K_WR, 5'd2, 16'hBEEF);
        wr_frame(MY_PHY, 5'd2, 16'hBEEF);
        check_drained("T6_write_after");
        rd_val = 16'h6C35;
        expect_read(5'd2, 16'h6C35, 1'b1);
        rd_frame(32, MY_PHY, 5'd2, 17);
        check_drained("T6_read_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
